fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// - Instruction fetch stage feeding the controller: owns the PC, fetches 32-bit words from instruction memory via a req/ready handshake.
// - Holds the fetched word in an instruction register and presents opcode/funct3/funct7b5 to the controller.
// - Computes next PC from the controller's PC_select once the datapath signals the instruction is consumed.
// PARAMETERS
// - RESET_PC    32'h0000_0000  PC value loaded on reset; must be word aligned
// - COUNT_WIDTH 16             width of retired-instruction counter
// PORTS
// - clock        in   1   rising-edge clock
// - reset        in   1   asynchronous, active-low reset
// - mem_req      out  1   fetch request to instruction memory
// - mem_addr     out  32  fetch address (== PC while mem_req high)
// - mem_ready    in   1   memory returns mem_rdata this cycle
// - mem_rdata    in   32  fetched instruction word
// - PC_select    in   2   from controller: 00 PC+4, 01 PC_target, 10 ALU_result, 11 PC+4
// - PC_target    in   32  branch/jal target from datapath
// - ALU_result   in   32  jalr target from datapath
// - advance      in   1   datapath has executed current instruction; load next PC
// - instr_valid  out  1   instruction/opcode/funct fields valid
// - instruction  out  32  instruction register
// - opcode       out  7   instruction[6:0]
// - funct3       out  3   instruction[14:12]
// - funct7b5     out  1   instruction[30]
// - PC           out  32  address of current instruction
// - PC_plus4     out  32  PC + 4 (combinational, for jal link)
// - fault        out  1   sticky misaligned-fetch fault
// - retired      out  COUNT_WIDTH  count of accepted advance pulses, wraps
// BEHAVIOUR
// - Reset (async, reset==0): state=FETCH, PC=RESET_PC, instruction=32'h0000_0013 (nop), instr_valid=0, fault=0, retired=0. mem_req=1 from first cycle after release.
// - States: FETCH, HOLD, FAULT.
// - FETCH: mem_req=1, mem_addr=PC, stable until mem_ready. On mem_ready: instruction<=mem_rdata, go HOLD. Any number of wait cycles allowed.
// - HOLD: mem_req=0, instr_valid=1. On advance: PC<=next_PC, retired<=retired+1, go FETCH (or FAULT, see trap). Without advance, all outputs hold.
// - Latency: mem_ready in cycle N -> instr_valid=1 in cycle N+1; advance in cycle M -> mem_req=1 with new address in cycle M+1. Minimum 2 cycles per instruction.
// - next_PC: 00/11 -> PC+4; 01 -> PC_target; 10 -> {ALU_result[31:1],1'b0} (jalr LSB clear).
// - Arithmetic: 32-bit modulo; PC 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag. retired wraps at 2^COUNT_WIDTH.
// - Ignored inputs: mem_ready outside FETCH; advance outside HOLD; PC_select/targets sampled only on advance in HOLD.
// - Reset asserted mid-fetch or mid-hold: immediate return to reset values; pending memory response discarded.
// - opcode/funct3/funct7b5 are pure slices of instruction register; instruction register changes only on FETCH capture or reset.
// CONFIGURATION
// - MISALIGN_TRAP_EN defined: on advance with next_PC[1:0]!=2'b00, PC<=next_PC, fault<=1, go FAULT; FAULT: mem_req=0, instr_valid=0, exits only via reset. retired still increments.
// - MISALIGN_TRAP_EN undefined: next_PC[1:0] forced to 2'b00, FAULT state unreachable, fault tied 0.
// TESTING
// - Reset release, mem_ready=1 same cycle as mem_req, mem_rdata=32'h0000_2083 (lw) -> mem_addr=0, next cycle instr_valid=1, opcode=7'b0000011, funct3=3'b010.
// - Wait states: hold mem_ready=0 for 3 cycles -> mem_req=1 and mem_addr constant all 3 cycles; instr_valid=0 throughout.
// - Sequential: PC=0x10, advance with PC_select=00 -> next mem_addr=0x14, retired +1; PC_select=01, PC_target=0x40 -> mem_addr=0x40.
// - jalr: PC_select=10, ALU_result=0x0000_0101 -> mem_addr=0x100; PC=0xFFFF_FFFC with PC_select=00 -> mem_addr=0x0.
// - Misaligned: PC_target=0x22, PC_select=01, advance -> with MISALIGN_TRAP_EN fault=1, mem_req=0 permanently; without, mem_addr=0x20, fault=0.
// - Reset mid-fetch (reset low while mem_req=1, mem_ready=0) -> outputs immediately at reset values, instruction=0x13; after release mem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch channel: request/address out, ready/data back.
// The fetch unit drives the master side and the instruction memory the slave side.
interface fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over fetch_unit_if and holds them for
// the controller. Optional MISALIGN_TRAP_EN turns misaligned next-PC into a sticky fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  fetch_unit_if.master           mem,
  input  logic [1:0]             PC_select,
  input  logic [31:0]            PC_target,
  input  logic [31:0]            ALU_result,
  input  logic                   advance,
  output logic                   instr_valid,
  output logic [31:0]            instruction,
  output logic [6:0]             opcode,
  output logic [2:0]             funct3,
  output logic                   funct7b5,
  output logic [31:0]            PC,
  output logic [31:0]            PC_plus4,
  output logic                   fault,
  output logic [COUNT_WIDTH-1:0] retired
);

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StFault = 2'd2
  } state_e;

  state_e                 state_q;
  logic [31:0]            pc_q;
  logic [31:0]            instr_q;
  logic                   req_q;
  logic                   valid_q;
  logic [COUNT_WIDTH-1:0] retired_q;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        misaligned;

  // jalr clears bit 0 before any alignment handling, so ALU_result[0] never matters.
  logic unused_alu_lsb;
  assign unused_alu_lsb = ALU_result[0];

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    target = pc_plus4;
    case (PC_select)
      2'b01:   target = PC_target;
      2'b10:   target = {ALU_result[31:1], 1'b0};
      default: target = pc_plus4;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign next_pc    = target;
  assign misaligned = |target[1:0];
`else
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^target[1:0];
  assign next_pc            = {target[31:2], 2'b00};
  assign misaligned         = 1'b0;
`endif

`ifdef MISALIGN_TRAP_EN
  logic fault_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      instr_q   <= NopInstr;
      req_q     <= 1'b1;
      valid_q   <= 1'b0;
      retired_q <= '0;
`ifdef MISALIGN_TRAP_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StFetch: begin
          if (mem.mem_ready) begin
            instr_q <= mem.mem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (advance) begin
            pc_q      <= next_pc;
            retired_q <= retired_q + COUNT_WIDTH'(1);
            valid_q   <= 1'b0;
            if (misaligned) begin
`ifdef MISALIGN_TRAP_EN
              fault_q <= 1'b1;
`endif
              req_q   <= 1'b0;
              state_q <= StFault;
            end else begin
              req_q   <= 1'b1;
              state_q <= StFetch;
            end
          end
        end
        StFault: begin
          // Terminal until reset.
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: begin
          req_q   <= 1'b1;
          valid_q <= 1'b0;
          state_q <= StFetch;
        end
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = pc_q;

  assign instr_valid = valid_q;
  assign instruction = instr_q;
  assign opcode      = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7b5    = instr_q[30];
  assign PC          = pc_q;
  assign PC_plus4    = pc_plus4;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int unsigned Cw      = 16;

  logic            clock;
  logic            reset;
  logic [1:0]      PC_select;
  logic [31:0]     PC_target;
  logic [31:0]     ALU_result;
  logic            advance;
  logic            instr_valid;
  logic [31:0]     instruction;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic [31:0]     PC;
  logic [31:0]     PC_plus4;
  logic            fault;
  logic [Cw-1:0]   retired;

  fetch_unit_if mem ();

  fetch_unit #(
    .RESET_PC    (ResetPc),
    .COUNT_WIDTH (Cw)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mem         (mem),
    .PC_select   (PC_select),
    .PC_target   (PC_target),
    .ALU_result  (ALU_result),
    .advance     (advance),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .PC          (PC),
    .PC_plus4    (PC_plus4),
    .fault       (fault),
    .retired     (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The stage is either waiting on memory, holding a word, or dead after a trap.
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic        m_fetching;
  logic        m_valid;
  logic        m_fault;
  logic [Cw-1:0] m_ret;

  function automatic logic [31:0] raw_next(input logic [1:0] sel, input logic [31:0] pc,
                                           input logic [31:0] tgt, input logic [31:0] alu);
    if (sel == 2'd1) return tgt;
    if (sel == 2'd2) return alu & 32'hFFFF_FFFE;
    return pc + 32'd4;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pc       <= ResetPc;
      m_ir       <= 32'h0000_0013;
      m_fetching <= 1'b1;
      m_valid    <= 1'b0;
      m_fault    <= 1'b0;
      m_ret      <= '0;
    end else if (m_fetching && mem.mem_ready) begin
      m_ir       <= mem.mem_rdata;
      m_fetching <= 1'b0;
      m_valid    <= 1'b1;
    end else if (m_valid && advance) begin
      m_ret   <= m_ret + 1'b1;
      m_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      m_pc <= raw_next(PC_select, m_pc, PC_target, ALU_result);
      if ((raw_next(PC_select, m_pc, PC_target, ALU_result) & 32'd3) != 0) m_fault <= 1'b1;
      else m_fetching <= 1'b1;
`else
      m_pc       <= raw_next(PC_select, m_pc, PC_target, ALU_result) & 32'hFFFF_FFFC;
      m_fetching <= 1'b1;
`endif
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("mem_req", {31'd0, mem.mem_req}, {31'd0, m_fetching});
      if (m_fetching) check("mem_addr", mem.mem_addr, m_pc);
      check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      check("instruction", instruction, m_ir);
      check("opcode", {25'd0, opcode}, m_ir & 32'h7F);
      check("funct3", {29'd0, funct3}, (m_ir >> 12) & 32'h7);
      check("funct7b5", {31'd0, funct7b5}, (m_ir >> 30) & 32'h1);
      check("pc", PC, m_pc);
      check("pc_plus4", PC_plus4, m_pc + 32'd4);
      check("fault", {31'd0, fault}, {31'd0, m_fault});
      check("retired", {16'd0, retired}, {16'd0, m_ret});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Precondition: DUT fetching at exp_addr. Leaves it holding word w.
  task automatic fetch_word(input logic [31:0] w, input int waits, input logic [31:0] exp_addr);
    mem.mem_ready = 1'b0;
    for (int i = 0; i < waits; i++) begin
      step();
      check("wait_req", {31'd0, mem.mem_req}, 32'd1);
      check("wait_addr", mem.mem_addr, exp_addr);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    mem.mem_ready = 1'b1;
    mem.mem_rdata = w;
    step();
    mem.mem_ready = 1'b0;
    check("captured_valid", {31'd0, instr_valid}, 32'd1);
    check("captured_word", instruction, w);
  endtask

  task automatic advance_to(input logic [1:0] sel, input logic [31:0] tgt, input logic [31:0] alu);
    PC_select  = sel;
    PC_target  = tgt;
    ALU_result = alu;
    advance    = 1'b1;
    step();
    advance    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b0;
    advance       = 1'b0;
    PC_select     = 2'd0;
    PC_target     = 32'd0;
    ALU_result    = 32'd0;
    mem.mem_ready = 1'b0;
    mem.mem_rdata = 32'd0;
    repeat (3) step();
    chk_en = 1'b1;

    check("rst_instruction", instruction, 32'h0000_0013);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", PC, ResetPc);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_retired", {16'd0, retired}, 32'd0);

    // First fetch with memory ready in the same cycle as the request.
    mem.mem_ready = 1'b1;
    mem.mem_rdata = 32'h0000_2083;
    reset         = 1'b1;
    check("first_req", {31'd0, mem.mem_req}, 32'd1);
    check("first_addr", mem.mem_addr, 32'h0);
    step();
    mem.mem_ready = 1'b0;
    check("lw_valid", {31'd0, instr_valid}, 32'd1);
    check("lw_opcode", {25'd0, opcode}, 32'h03);
    check("lw_funct3", {29'd0, funct3}, 32'h2);
    check("lw_req_low", {31'd0, mem.mem_req}, 32'd0);

    advance_to(2'b01, 32'h10, 32'h0);
    check("tgt_addr", mem.mem_addr, 32'h10);
    check("tgt_retired", {16'd0, retired}, 32'd1);
    fetch_word(32'h0041_8033, 3, 32'h10);

    advance_to(2'b00, 32'h0, 32'h0);
    check("seq_addr", mem.mem_addr, 32'h14);
    check("seq_retired", {16'd0, retired}, 32'd2);
    check("model_pc_seq", m_pc, 32'h14);
    fetch_word(32'h4000_0033, 0, 32'h14);
    check("funct7b5_set", {31'd0, funct7b5}, 32'd1);

    advance_to(2'b01, 32'h40, 32'h0);
    check("branch_addr", mem.mem_addr, 32'h40);
    fetch_word(32'h0000_0067, 1, 32'h40);

    advance_to(2'b10, 32'h0, 32'h0000_0101);
    check("jalr_addr", mem.mem_addr, 32'h100);
    check("model_pc_jalr", m_pc, 32'h100);
    fetch_word(32'h0000_0013, 0, 32'h100);

    advance_to(2'b01, 32'hFFFF_FFFC, 32'h0);
    check("top_addr", mem.mem_addr, 32'hFFFF_FFFC);
    fetch_word(32'h0000_0013, 0, 32'hFFFF_FFFC);
    advance_to(2'b11, 32'h0, 32'h0);
    check("wrap_addr", mem.mem_addr, 32'h0);
    check("wrap_plus4", PC_plus4, 32'h4);
    fetch_word(32'h0000_0013, 0, 32'h0);

    advance_to(2'b01, 32'h22, 32'h0);
`ifdef MISALIGN_TRAP_EN
    check("trap_fault", {31'd0, fault}, 32'd1);
    check("trap_pc", PC, 32'h22);
    mem.mem_ready = 1'b1;
    advance       = 1'b1;
    repeat (3) begin
      step();
      check("trap_req", {31'd0, mem.mem_req}, 32'd0);
      check("trap_valid", {31'd0, instr_valid}, 32'd0);
    end
    mem.mem_ready = 1'b0;
    advance       = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    fetch_word(32'h0000_0013, 0, 32'h0);
    advance_to(2'b01, 32'h80, 32'h0);
`else
    check("align_addr", mem.mem_addr, 32'h20);
    check("align_fault", {31'd0, fault}, 32'd0);
`endif

    // Reset in the middle of a stalled fetch.
    mem.mem_ready = 1'b0;
    step();
    check("midfetch_req", {31'd0, mem.mem_req}, 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_instruction", instruction, 32'h0000_0013);
    check("midrst_pc", PC, ResetPc);
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_retired", {16'd0, retired}, 32'd0);
    check("midrst_fault", {31'd0, fault}, 32'd0);
    step();
    reset = 1'b1;
    step();
    check("post_rst_req", {31'd0, mem.mem_req}, 32'd1);
    check("post_rst_addr", mem.mem_addr, ResetPc);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int c = 0; c < 4000; c++) begin
      reset         = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      mem.mem_ready = $urandom_range(0, 1) == 1;
      mem.mem_rdata = $urandom;
      advance       = $urandom_range(0, 9) < 4;
      PC_select     = 2'($urandom_range(0, 3));
      PC_target     = $urandom;
      ALU_result    = $urandom;
      if ($urandom_range(0, 99) >= 3) begin
        PC_target  = PC_target & 32'hFFFF_FFFC;
        ALU_result = ALU_result & 32'hFFFF_FFFD;
      end
      step();
    end

    reset   = 1'b1;
    advance = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
